sw_target_streamer: RTL and testbench
=====================================

// Module: sw_target_streamer
// PURPOSE
// - Host-side end of the SW_ProcessingElement systolic array. Buffers one target sequence, then drives PE0's en_in/data_in/M_in/I_in/High_in.
// - Collects the last PE's High_out on its vld pulse and returns the unbiased score to the host through a valid/ready handshake.
// - Store-and-forward is required: the PE array needs en high, gap-free, for the whole sequence.
// PARAMETERS
// - SCORE_WIDTH  12               score width; must match the array
// - MAX_LEN      256              max target bases per sequence
// - LEN_W        $clog2(MAX_LEN+1) length counter width
// - NUM_PE       32               PEs in the array (query length)
// - TIMEOUT      NUM_PE+8         DRAIN watchdog, in cycles
// PORTS
// - clk          in   1   single clock domain
// - rst          in   1   synchronous, active-high; top-level inverts it for the PEs (active-low)
// - s_valid      in   1   target base valid
// - s_ready      out  1   streamer accepts base
// - s_base       in   2   base: A=00 G=01 T=10 C=11
// - s_last       in   1   final base of sequence
// - pe_en        out  1   to PE0 en_in
// - pe_data      out  2   to PE0 data_in
// - pe_M         out  SW  to PE0 M_in; constant ZERO
// - pe_I         out  SW  to PE0 I_in; constant ZERO
// - pe_High      out  SW  to PE0 High_in; constant ZERO
// - pe_High_last in   SW  last PE High_out
// - pe_vld_last  in   1   last PE vld
// - r_valid      out  1   result valid
// - r_ready      in   1   host accepts result
// - r_score      out  SW  unbiased best score
// - r_len        out  LEN_W  bases actually streamed
// - r_err        out  1   overflow or timeout
// BEHAVIOUR
// - ZERO = 2**(SCORE_WIDTH-1), the biased zero.
// - Reset values: pe_en=0, pe_data=00, r_valid=0, r_score=0, r_len=0, r_err=0, s_ready=0, FSM=IDLE.
// - pe_M/pe_I/pe_High equal ZERO at all times.
// - FSM states: IDLE, LOAD, STREAM, DRAIN, RESULT.
// - IDLE: s_ready=1 starting the first cycle after reset. The first accepted beat writes buf[0] and moves the FSM to LOAD.
// - A beat with s_last accepted in IDLE is a length-1 sequence and goes directly to STREAM.
// - LOAD: s_ready=1. Each s_valid&&s_ready writes buf[wr_ptr] and increments wr_ptr. s_valid gaps are allowed.
// - LOAD exit: when the s_last beat is accepted, go to STREAM and drive s_ready=0 from the next cycle.
// - Overflow: a beat beyond MAX_LEN without s_last is accepted but discarded. Discard continues until s_last. ovf flag is set; length stays MAX_LEN.
// - STREAM: s_ready=0. Buffer read is synchronous with a one-cycle prefetch.
// - pe_en rises exactly 2 cycles after the s_last beat is accepted. It stays high for exactly len consecutive cycles; pe_data=buf[i] on the i-th cycle.
// - After the final base, pe_en=0 and the FSM moves to DRAIN.
// - DRAIN: watchdog counts from 0. On the first cycle with pe_vld_last=1, capture pe_High_last and go to RESULT.
// - Timeout: if the counter reaches TIMEOUT, capture ZERO, set r_err, and go to RESULT.
// - Score: r_score = pe_High_last-ZERO when pe_High_last>=ZERO, else 0. r_len=len. r_err = ovf | timeout.
// - RESULT: r_valid=1. r_score/r_len/r_err stay stable until r_valid&&r_ready.
// - On handshake: r_valid=0 next cycle, FSM returns to IDLE, ovf is cleared.
// - pe_vld_last outside DRAIN is ignored.
// - pe_en is low for at least 3 cycles between sequences, covering the IDLE/LOAD/RESULT path. PEs always see en fall and re-rise.
// - rst asserted in any state: next cycle all outputs take reset values, buffer contents are discarded, pe_en drops immediately.
// STRUCTURE
// - sw_pkg (shared with the PE):
//   - SCORE_WIDTH default and base encodings _A/_G/_T/_C.
//   - ZERO bias function and the unbias/clamp function.
// - Sub-module sw_base_buffer: MAX_LEN x 2-bit simple dual-port RAM, one write port, synchronous read.
// - Top contains the FSM, wr_ptr/rd_ptr/len counters, watchdog and result registers.
// TESTING
// 1. Reset: rst=1 for 2 cycles, then 0 -> pe_en=0, r_valid=0, pe_M=pe_I=pe_High=2048; s_ready=1 one cycle after rst falls.
// 2. Feed A,G,T,C back-to-back, s_last on C -> s_ready=0 the next cycle; pe_en high 4 contiguous cycles starting 2 cycles after C; pe_data=00,01,10,11.
// 3. Feed 8 bases with s_valid toggling 1/0 -> pe_en still 8 contiguous cycles; pe_data matches input order.
// 4. Drive pe_vld_last pulse with pe_High_last=2065, r_ready held low 5 cycles -> r_valid=1, r_score=17, r_len=4, r_err=0, all stable; r_valid=0 the cycle after r_ready=1.
// 5. Never assert pe_vld_last -> TIMEOUT cycles after DRAIN entry: r_valid=1, r_score=0, r_err=1.
// 6. MAX_LEN=8, feed 10 bases -> pe_en 8 cycles, r_len=8, r_err=1; separately, assert rst mid-STREAM -> pe_en=0 the next cycle, FSM=IDLE.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array and its host-side streamer:
// base encodings, the biased-zero score representation and streamer FSM states.
package sw_pkg;

    localparam int SW_SCORE_WIDTH = 12;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_G = 2'b01;
    localparam logic [1:0] BASE_T = 2'b10;
    localparam logic [1:0] BASE_C = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_RESULT
    } stream_state_e;

    // Scores travel through the array offset by half the range so they never go negative.
    function automatic int unsigned zero_bias(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned unbias_clamp(input int unsigned score, input int w);
        int unsigned bias;
        bias = zero_bias(w);
        return (score >= bias) ? (score - bias) : 32'd0;
    endfunction

endpackage

// File: rtl/sw_base_buffer.sv
// Simple dual-port target-base store: one write port, one registered read port.
module sw_base_buffer #(
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [1:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [1:0]    rdata_o
);

    logic [1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/sw_target_streamer.sv
// Host-side end of the SW systolic array: buffers a whole target sequence, replays it
// gap-free into PE0, then returns the last PE's best score through a valid/ready port.
module sw_target_streamer
    import sw_pkg::*;
#(
    parameter int SCORE_WIDTH = SW_SCORE_WIDTH,
    parameter int MAX_LEN     = 256,
    parameter int LEN_W       = $clog2(MAX_LEN + 1),
    parameter int NUM_PE      = 32,
    parameter int TIMEOUT     = NUM_PE + 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [1:0]             s_base,
    input  logic                   s_last,
    output logic                   pe_en,
    output logic [1:0]             pe_data,
    output logic [SCORE_WIDTH-1:0] pe_M,
    output logic [SCORE_WIDTH-1:0] pe_I,
    output logic [SCORE_WIDTH-1:0] pe_High,
    input  logic [SCORE_WIDTH-1:0] pe_High_last,
    input  logic                   pe_vld_last,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [SCORE_WIDTH-1:0] r_score,
    output logic [LEN_W-1:0]       r_len,
    output logic                   r_err
);

    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(zero_bias(SCORE_WIDTH));

    stream_state_e state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   ovf_q, ovf_d;
    logic                   s_ready_q, s_ready_d;
    logic                   pe_en_q, pe_en_d;
    logic                   r_valid_q, r_valid_d;
    logic [SCORE_WIDTH-1:0] r_score_q, r_score_d;
    logic [LEN_W-1:0]       r_len_q, r_len_d;
    logic                   r_err_q, r_err_d;

    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic          buf_re;
    logic [1:0]    buf_rdata;
    logic          accept;

    assign accept = s_valid && s_ready_q;

    sw_base_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (s_base),
        .re_i    (buf_re),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rd_ptr_d  = rd_ptr_q;
        wd_d      = wd_q;
        ovf_d     = ovf_q;
        pe_en_d   = 1'b0;
        r_valid_d = r_valid_q;
        r_score_d = r_score_q;
        r_len_d   = r_len_q;
        r_err_d   = r_err_q;
        buf_we    = 1'b0;
        buf_waddr = len_q[AW-1:0];
        buf_re    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    len_d     = LEN_W'(1);
                    ovf_d     = 1'b0;
                    rd_ptr_d  = '0;
                    state_d   = s_last ? ST_STREAM : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    // Beats past the buffer capacity are swallowed so the host never stalls.
                    if (len_q < LEN_W'(MAX_LEN)) begin
                        buf_we = 1'b1;
                        len_d  = len_q + LEN_W'(1);
                    end else begin
                        ovf_d = 1'b0 | 1'b1;
                    end
                    if (s_last) begin
                        rd_ptr_d = '0;
                        state_d  = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (rd_ptr_q < len_q) begin
                    buf_re   = 1'b1;
                    pe_en_d  = 1'b1;
                    rd_ptr_d = rd_ptr_q + LEN_W'(1);
                end else begin
                    wd_d    = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pe_vld_last) begin
                    r_score_d = SCORE_WIDTH'(unbias_clamp(32'(pe_High_last), SCORE_WIDTH));
                    r_len_d   = len_q;
                    r_err_d   = ovf_q;
                    r_valid_d = 1'b1;
                    state_d   = ST_RESULT;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    r_score_d = SCORE_WIDTH'(unbias_clamp(32'(ZERO), SCORE_WIDTH));
                    r_len_d   = len_q;
                    r_err_d   = 1'b1;
                    r_valid_d = 1'b1;
                    state_d   = ST_RESULT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RESULT: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            rd_ptr_q  <= '0;
            wd_q      <= '0;
            ovf_q     <= 1'b0;
            s_ready_q <= 1'b0;
            pe_en_q   <= 1'b0;
            r_valid_q <= 1'b0;
            r_score_q <= '0;
            r_len_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rd_ptr_q  <= rd_ptr_d;
            wd_q      <= wd_d;
            ovf_q     <= ovf_d;
            s_ready_q <= s_ready_d;
            pe_en_q   <= pe_en_d;
            r_valid_q <= r_valid_d;
            r_score_q <= r_score_d;
            r_len_q   <= r_len_d;
            r_err_q   <= r_err_d;
        end
    end

    // The RAM read register is not reset, so data is forced to A whenever en is low.
    assign pe_data = pe_en_q ? buf_rdata : 2'b00;
    assign pe_en   = pe_en_q;
    assign s_ready = s_ready_q;
    assign pe_M    = ZERO;
    assign pe_I    = ZERO;
    assign pe_High = ZERO;
    assign r_valid = r_valid_q;
    assign r_score = r_score_q;
    assign r_len   = r_len_q;
    assign r_err   = r_err_q;

endmodule

// File: tb/tb_sw_target_streamer.sv
// Directed bench for sw_target_streamer with an 8-entry buffer: load, stream,
// result handshake, watchdog timeout, overflow, score clamping and mid-stream reset.
module tb_sw_target_streamer;
    import sw_pkg::*;

    localparam int SW      = 12;
    localparam int MAXL    = 8;
    localparam int LW      = 4;
    localparam int TIMEOUT = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:0]    s_base = 2'b00;
    logic          s_last = 1'b0;
    logic          pe_en;
    logic [1:0]    pe_data;
    logic [SW-1:0] pe_M, pe_I, pe_High;
    logic [SW-1:0] pe_High_last = '0;
    logic          pe_vld_last = 1'b0;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic [SW-1:0] r_score;
    logic [LW-1:0] r_len;
    logic          r_err;

    int vectors = 0;
    int miscompares = 0;

    sw_target_streamer #(
        .SCORE_WIDTH (SW),
        .MAX_LEN     (MAXL),
        .NUM_PE      (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_base       (s_base),
        .s_last       (s_last),
        .pe_en        (pe_en),
        .pe_data      (pe_data),
        .pe_M         (pe_M),
        .pe_I         (pe_I),
        .pe_High      (pe_High),
        .pe_High_last (pe_High_last),
        .pe_vld_last  (pe_vld_last),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_score      (r_score),
        .r_len        (r_len),
        .r_err        (r_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [1:0] b, input logic last);
        s_valid = 1'b1;
        s_base  = b;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (pe_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pe_en got %0d want 0", pe_en); end
        vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_r_valid got %0d want 0", r_valid); end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_s_ready got %0d want 0", s_ready); end
        vectors++; if ({r_score, r_len, r_err} !== '0) begin miscompares++; $display("[TB] FAIL reset_result got %0d/%0d/%0d want 0/0/0", r_score, r_len, r_err); end
        vectors++; if (pe_M !== 12'd2048 || pe_I !== 12'd2048 || pe_High !== 12'd2048) begin
            miscompares++; $display("[TB] FAIL reset_bias got %0d/%0d/%0d want 2048", pe_M, pe_I, pe_High);
        end
        rst = 1'b0;
        tick();
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_s_ready got %0d want 1", s_ready); end
        vectors++; if (pe_en !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_pe_en got %0d want 0", pe_en); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] bases [4];
        bases = '{BASE_A, BASE_G, BASE_T, BASE_C};
        for (int i = 0; i < 4; i++) begin
            vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_s_ready beat %0d got %0d want 1", i, s_ready); end
            send_beat(bases[i], i == 3);
        end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_s_ready_after_last got %0d want 0", s_ready); end
        vectors++; if (pe_en !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_pe_en_early got %0d want 0", pe_en); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (pe_en !== 1'b1 || pe_data !== bases[i]) begin
                miscompares++; $display("[TB] FAIL b2b_stream cyc %0d got en=%0d data=%0d want en=1 data=%0d", i, pe_en, pe_data, bases[i]);
            end
        end
        tick();
        vectors++; if (pe_en !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_pe_en_fall got %0d want 0", pe_en); end
    endtask

    task automatic test_result_handshake();
        pe_vld_last  = 1'b1;
        pe_High_last = 12'd2065;
        tick();
        pe_vld_last  = 1'b0;
        pe_High_last = 12'd0;
        for (int k = 0; k < 5; k++) begin
            vectors++; if (r_valid !== 1'b1 || r_score !== 12'd17 || r_len !== 4'd4 || r_err !== 1'b0) begin
                miscompares++; $display("[TB] FAIL hold_result cyc %0d got v=%0d s=%0d l=%0d e=%0d want v=1 s=17 l=4 e=0", k, r_valid, r_score, r_len, r_err);
            end
            tick();
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL handshake_r_valid got %0d want 0", r_valid); end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL handshake_s_ready got %0d want 1", s_ready); end
    endtask

    task automatic test_gapped_load();
        logic [1:0] bases [8];
        bases = '{BASE_T, BASE_C, BASE_A, BASE_A, BASE_G, BASE_C, BASE_T, BASE_G};
        pe_vld_last  = 1'b1;
        pe_High_last = 12'd2100;
        tick();
        pe_vld_last  = 1'b0;
        vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_vld_ignored got %0d want 0", r_valid); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL gap_s_ready beat %0d got %0d want 1", i, s_ready); end
            send_beat(bases[i], i == 7);
            if (i != 7) tick();
        end
        vectors++; if (s_ready !== 1'b0 || pe_en !== 1'b0) begin
            miscompares++; $display("[TB] FAIL gap_after_last got rdy=%0d en=%0d want 0/0", s_ready, pe_en);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++; if (pe_en !== 1'b1 || pe_data !== bases[i]) begin
                miscompares++; $display("[TB] FAIL gap_stream cyc %0d got en=%0d data=%0d want en=1 data=%0d", i, pe_en, pe_data, bases[i]);
            end
        end
        tick();
        vectors++; if (pe_en !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_pe_en_fall got %0d want 0", pe_en); end
    endtask

    task automatic test_timeout();
        int cycles;
        cycles = 0;
        while (r_valid !== 1'b1 && cycles < TIMEOUT + 10) begin
            tick();
            cycles++;
        end
        vectors++; if (cycles != TIMEOUT) begin miscompares++; $display("[TB] FAIL timeout_latency got %0d want %0d", cycles, TIMEOUT); end
        vectors++; if (r_valid !== 1'b1 || r_score !== 12'd0 || r_err !== 1'b1 || r_len !== 4'd8) begin
            miscompares++; $display("[TB] FAIL timeout_result got v=%0d s=%0d e=%0d l=%0d want v=1 s=0 e=1 l=8", r_valid, r_score, r_err, r_len);
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_handshake got %0d want 0", r_valid); end
    endtask

    task automatic test_overflow();
        logic [1:0] bases [10];
        bases = '{BASE_C, BASE_A, BASE_G, BASE_T, BASE_T, BASE_G, BASE_A, BASE_C, BASE_G, BASE_G};
        for (int i = 0; i < 10; i++) begin
            vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_s_ready beat %0d got %0d want 1", i, s_ready); end
            send_beat(bases[i], i == 9);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++; if (pe_en !== 1'b1 || pe_data !== bases[i]) begin
                miscompares++; $display("[TB] FAIL ovf_stream cyc %0d got en=%0d data=%0d want en=1 data=%0d", i, pe_en, pe_data, bases[i]);
            end
        end
        tick();
        vectors++; if (pe_en !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_pe_en_fall got %0d want 0", pe_en); end
        pe_vld_last  = 1'b1;
        pe_High_last = 12'd2053;
        tick();
        pe_vld_last  = 1'b0;
        vectors++; if (r_valid !== 1'b1 || r_score !== 12'd5 || r_len !== 4'd8 || r_err !== 1'b1) begin
            miscompares++; $display("[TB] FAIL ovf_result got v=%0d s=%0d l=%0d e=%0d want v=1 s=5 l=8 e=1", r_valid, r_score, r_len, r_err);
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    task automatic test_single_clamp();
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL single_s_ready got %0d want 1", s_ready); end
        send_beat(BASE_G, 1'b1);
        vectors++; if (s_ready !== 1'b0 || pe_en !== 1'b0) begin
            miscompares++; $display("[TB] FAIL single_after_last got rdy=%0d en=%0d want 0/0", s_ready, pe_en);
        end
        tick();
        vectors++; if (pe_en !== 1'b1 || pe_data !== BASE_G) begin
            miscompares++; $display("[TB] FAIL single_stream got en=%0d data=%0d want en=1 data=1", pe_en, pe_data);
        end
        tick();
        vectors++; if (pe_en !== 1'b0) begin miscompares++; $display("[TB] FAIL single_pe_en_fall got %0d want 0", pe_en); end
        pe_vld_last  = 1'b1;
        pe_High_last = 12'd2000;
        tick();
        pe_vld_last  = 1'b0;
        vectors++; if (r_valid !== 1'b1 || r_score !== 12'd0 || r_len !== 4'd1 || r_err !== 1'b0) begin
            miscompares++; $display("[TB] FAIL clamp_result got v=%0d s=%0d l=%0d e=%0d want v=1 s=0 l=1 e=0", r_valid, r_score, r_len, r_err);
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        send_beat(BASE_A, 1'b0);
        send_beat(BASE_T, 1'b0);
        send_beat(BASE_C, 1'b1);
        tick();
        vectors++; if (pe_en !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_stream_en got %0d want 1", pe_en); end
        rst = 1'b1;
        tick();
        vectors++; if (pe_en !== 1'b0 || s_ready !== 1'b0 || r_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL mid_reset got en=%0d rdy=%0d v=%0d want 0/0/0", pe_en, s_ready, r_valid);
        end
        rst = 1'b0;
        tick();
        vectors++; if (s_ready !== 1'b1 || pe_en !== 1'b0) begin
            miscompares++; $display("[TB] FAIL mid_reset_idle got rdy=%0d en=%0d want 1/0", s_ready, pe_en);
        end
        send_beat(BASE_T, 1'b1);
        tick();
        vectors++; if (pe_en !== 1'b1 || pe_data !== BASE_T) begin
            miscompares++; $display("[TB] FAIL restart_stream got en=%0d data=%0d want en=1 data=2", pe_en, pe_data);
        end
        tick();
        pe_vld_last  = 1'b1;
        pe_High_last = 12'd2049;
        tick();
        pe_vld_last  = 1'b0;
        vectors++; if (r_valid !== 1'b1 || r_score !== 12'd1 || r_len !== 4'd1 || r_err !== 1'b0) begin
            miscompares++; $display("[TB] FAIL restart_result got v=%0d s=%0d l=%0d e=%0d want v=1 s=1 l=1 e=0", r_valid, r_score, r_len, r_err);
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    initial begin
        $display("[TB] sw_target_streamer directed run");
        test_reset();
        test_back_to_back();
        test_result_handshake();
        test_gapped_load();
        test_timeout();
        test_overflow();
        test_single_clamp();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_watchdog got no finish want finish");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
